// File: rtl/branch_pkg.sv
// Shared branch types and helpers for the branch resolver and its direction predictor.
package branch_pkg;

   localparam int MAX_XLEN = 64;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_type_e;

   // Unknown or reserved funct3 codes fall to the default arm, so they never yield X.
   function automatic logic br_cond(input logic [2:0] brType, input logic zero,
                                    input logic [MAX_XLEN-1:0] aluResult);
      case (brType)
         BEQ:       return zero;
         BNE:       return ~zero;
         BLT, BLTU: return aluResult == MAX_XLEN'(1);
         BGE, BGEU: return aluResult == '0;
         default:   return 1'b0;
      endcase
   endfunction

   function automatic logic br_legal(input logic [2:0] brType);
      case (brType)
         BEQ, BNE, BLT, BGE, BLTU, BGEU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] sat_update(input logic [3:0] cnt, input logic up,
                                             input int width);
      logic [3:0] maxVal;
      maxVal = 4'((1 << width) - 1);
      if (up) return (cnt == maxVal) ? cnt : cnt + 4'd1;
      else    return (cnt == 4'd0)   ? cnt : cnt - 4'd1;
   endfunction

endpackage

// File: rtl/branch_predict_unit_bht_table.sv
// Saturating-counter table: combinational read for Fetch, read-modify-write update from Execute.
module bht_table
   import branch_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2,
   localparam int IDX        = $clog2(BHT_ENTRIES)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IDX-1:0]      rdIdx,
   output logic [CNT_BITS-1:0] rdCnt,
   input  logic                wrEn,
   input  logic [IDX-1:0]      wrIdx,
   input  logic                wrUp
);

   // Weakly not-taken: the value just below the MSB flip.
   localparam logic [CNT_BITS-1:0] INIT_CNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

   logic [CNT_BITS-1:0] cntArr [BHT_ENTRIES];

   assign rdCnt = cntArr[rdIdx];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) cntArr[i] <= INIT_CNT;
      end else if (wrEn) begin
         cntArr[wrIdx] <= CNT_BITS'(sat_update(4'(cntArr[wrIdx]), wrUp, CNT_BITS));
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution plus bimodal/gshare direction prediction for Fetch.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2,
   parameter int GHR_BITS    = 0,
   parameter int STAT_BITS   = 32,
   localparam int IDX        = $clog2(BHT_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [XLEN-1:0]      PCF,
   output logic                 PredictTakenF,
   output logic [IDX-1:0]       PredIdxF,
   input  logic                 BranchE,
   input  logic [2:0]           TypeBranchE,
   input  logic                 ZeroE,
   input  logic [XLEN-1:0]      ALUResultE,
   input  logic                 PredTakenE,
   input  logic [IDX-1:0]       PredIdxE,
   input  logic                 StallE,
   output logic                 NeedBranchE,
   output logic                 MispredictE,
   output logic [STAT_BITS-1:0] BranchCount,
   output logic [STAT_BITS-1:0] MispredictCount
);

   logic                cond;
   logic                legal;
   logic                resolve;
   logic [IDX-1:0]      pcIdx;
   logic [CNT_BITS-1:0] predCnt;
   logic                unusedPc;

   assign cond        = br_cond(TypeBranchE, ZeroE, MAX_XLEN'(ALUResultE));
   assign legal       = BranchE & br_legal(TypeBranchE);
   assign resolve     = legal & ~StallE;
   assign NeedBranchE = BranchE & cond;
   assign MispredictE = legal & (cond != PredTakenE);

   // Byte offset and PC bits above the table index do not take part in indexing.
   assign pcIdx    = PCF[IDX+1:2];
   assign unusedPc = ^{PCF[1:0], PCF[XLEN-1:IDX+2]};

   generate
      if (GHR_BITS > 0) begin : gGshare
         logic [GHR_BITS-1:0] ghr;

         // History advances only on resolved branches, never speculatively.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)     ghr <= '0;
            else if (resolve) ghr <= GHR_BITS'({ghr, cond});
         end

         assign PredIdxF = pcIdx ^ IDX'(ghr);
      end else begin : gBimodal
         assign PredIdxF = pcIdx;
      end
   endgenerate

   bht_table #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .CNT_BITS    (CNT_BITS)
   ) uTable (
      .clk     (clk),
      .reset_n (reset_n),
      .rdIdx   (PredIdxF),
      .rdCnt   (predCnt),
      .wrEn    (resolve),
      .wrIdx   (PredIdxE),
      .wrUp    (cond)
   );

   assign PredictTakenF = predCnt[CNT_BITS-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         BranchCount     <= '0;
         MispredictCount <= '0;
      end else if (resolve) begin
         BranchCount     <= BranchCount + STAT_BITS'(1);
         MispredictCount <= MispredictCount + STAT_BITS'(MispredictE);
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: one bimodal and one 4-bit gshare instance, hand-computed expectations.
module tb_branch_predict_unit;

   logic        clk;
   logic        reset_n;
   logic [31:0] pcf;
   logic [2:0]  typ;
   logic        zero;
   logic [31:0] alu;
   logic        predT;
   logic        stall;
   logic        brB, brG;
   logic [5:0]  idxB, idxG;

   logic        ptB, needB, misB;
   logic [5:0]  pidxB;
   logic [31:0] bcB, mcB;
   logic        ptG, needG, misG;
   logic [5:0]  pidxG;
   logic [31:0] bcG, mcG;

   int nVec = 0;
   int nMis = 0;

   branch_predict_unit uBim (
      .clk (clk), .reset_n (reset_n), .PCF (pcf),
      .PredictTakenF (ptB), .PredIdxF (pidxB),
      .BranchE (brB), .TypeBranchE (typ), .ZeroE (zero), .ALUResultE (alu),
      .PredTakenE (predT), .PredIdxE (idxB), .StallE (stall),
      .NeedBranchE (needB), .MispredictE (misB),
      .BranchCount (bcB), .MispredictCount (mcB)
   );

   branch_predict_unit #(.GHR_BITS (4)) uGsh (
      .clk (clk), .reset_n (reset_n), .PCF (pcf),
      .PredictTakenF (ptG), .PredIdxF (pidxG),
      .BranchE (brG), .TypeBranchE (typ), .ZeroE (zero), .ALUResultE (alu),
      .PredTakenE (predT), .PredIdxE (idxG), .StallE (stall),
      .NeedBranchE (needG), .MispredictE (misG),
      .BranchCount (bcG), .MispredictCount (mcG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic condCase(input string tag, input logic [2:0] t, input logic z,
                           input logic [31:0] a, input logic pt,
                           input logic expNeed, input logic expMis);
      typ = t; zero = z; alu = a; predT = pt;
      #1;
      checkVal({tag, "_need"}, 64'(needB), 64'(expNeed));
      checkVal({tag, "_mis"},  64'(misB),  64'(expMis));
   endtask

   initial begin
      reset_n = 1'b0; pcf = 32'h0; typ = 3'b000; zero = 1'b0; alu = 32'h0;
      predT = 1'b0; stall = 1'b0; brB = 1'b0; brG = 1'b0; idxB = 6'd0; idxG = 6'd0;
      #12 reset_n = 1'b1;

      // Reset state
      pcf = 32'h100;
      #1;
      checkVal("rst_pt",    64'(ptB),   64'd0);
      checkVal("rst_idx",   64'(pidxB), 64'h00);
      checkVal("rst_bc",    64'(bcB),   64'd0);
      checkVal("rst_mc",    64'(mcB),   64'd0);
      checkVal("rst_gidx",  64'(pidxG), 64'h00);

      // Condition decode, stalled so nothing updates
      brB = 1'b1; stall = 1'b1;
      condCase("beq_z1",   3'b000, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1);
      condCase("beq_z0",   3'b000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
      condCase("bne_z0",   3'b001, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1);
      condCase("bne_z1",   3'b001, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1);
      condCase("blt_1",    3'b100, 1'b0, 32'h1,        1'b0, 1'b1, 1'b1);
      condCase("blt_3",    3'b100, 1'b0, 32'h3,        1'b0, 1'b0, 1'b0);
      condCase("blt_hi",   3'b100, 1'b0, 32'h80000001, 1'b1, 1'b0, 1'b1);
      condCase("bge_0",    3'b101, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1);
      condCase("bge_1",    3'b101, 1'b0, 32'h1,        1'b0, 1'b0, 1'b0);
      condCase("bltu_1",   3'b110, 1'b0, 32'h1,        1'b1, 1'b1, 1'b0);
      condCase("bgeu_0",   3'b111, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1);
      condCase("bgeu_big", 3'b111, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0);
      condCase("ill_010",  3'b010, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0);
      condCase("ill_011",  3'b011, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0);
      tick();
      checkVal("stall_bc", 64'(bcB), 64'd0);
      checkVal("stall_pt", 64'(ptB), 64'd0);

      // Bimodal idx 0: three taken resolutions, predicted not-taken
      stall = 1'b0; typ = 3'b000; zero = 1'b1; predT = 1'b0; idxB = 6'd0;
      #1;
      checkVal("t0_pt_old", 64'(ptB),  64'd0);
      checkVal("t0_mis",    64'(misB), 64'd1);
      tick();
      checkVal("t1_pt", 64'(ptB), 64'd1);
      tick();
      checkVal("t2_pt", 64'(ptB), 64'd1);
      tick();
      checkVal("t3_pt_sat", 64'(ptB), 64'd1);
      checkVal("t3_bc",     64'(bcB), 64'd3);
      checkVal("t3_mc",     64'(mcB), 64'd3);

      // Four not-taken resolutions, predicted taken: 11->10->01->00->00
      zero = 1'b0; predT = 1'b1;
      #1;
      checkVal("n0_pt_old", 64'(ptB),  64'd1);
      checkVal("n0_mis",    64'(misB), 64'd1);
      tick();
      checkVal("n1_pt", 64'(ptB), 64'd1);
      tick();
      checkVal("n2_pt", 64'(ptB), 64'd0);
      tick();
      checkVal("n3_pt", 64'(ptB), 64'd0);
      tick();
      checkVal("n4_pt_sat", 64'(ptB), 64'd0);
      checkVal("n4_bc",     64'(bcB), 64'd7);
      checkVal("n4_mc",     64'(mcB), 64'd7);
      zero = 1'b1; predT = 1'b0;
      tick();
      checkVal("n5_pt", 64'(ptB), 64'd0);
      checkVal("n5_bc", 64'(bcB), 64'd8);
      checkVal("n5_mc", 64'(mcB), 64'd8);

      // gshare history T,T,N,T -> 1101
      brB = 1'b0; brG = 1'b1; idxG = 6'd0;
      #1;
      checkVal("g_idx0", 64'(pidxG), 64'h00);
      zero = 1'b1; tick();
      zero = 1'b1; tick();
      zero = 1'b0; tick();
      zero = 1'b1; tick();
      checkVal("g_idx", 64'(pidxG), 64'h0D);
      checkVal("g_bc",  64'(bcG),   64'd4);
      checkVal("b_bc_idle", 64'(bcB), 64'd8);

      // Stall with a mismatch: flags visible, no state change
      brG = 1'b0; brB = 1'b1; stall = 1'b1; typ = 3'b000; zero = 1'b1; predT = 1'b0;
      #1;
      checkVal("st_mis",  64'(misB),  64'd1);
      checkVal("st_need", 64'(needB), 64'd1);
      tick();
      checkVal("st_pt", 64'(ptB), 64'd0);
      checkVal("st_bc", 64'(bcB), 64'd8);
      checkVal("st_mc", 64'(mcB), 64'd8);

      // Illegal type, not stalled: no flags, no update
      stall = 1'b0; typ = 3'b010; predT = 1'b1;
      #1;
      checkVal("il_need", 64'(needB), 64'd0);
      checkVal("il_mis",  64'(misB),  64'd0);
      tick();
      checkVal("il_bc", 64'(bcB), 64'd8);
      checkVal("il_pt", 64'(ptB), 64'd0);

      // Async reset while a resolution is pending
      typ = 3'b000; zero = 1'b1; predT = 1'b0; brB = 1'b1; brG = 1'b1;
      tick();
      checkVal("pre_pt",   64'(ptB),   64'd1);
      checkVal("pre_bc",   64'(bcB),   64'd9);
      checkVal("pre_gidx", 64'(pidxG), 64'h0B);
      #2 reset_n = 1'b0;
      #1;
      checkVal("ar_pt",   64'(ptB),   64'd0);
      checkVal("ar_bc",   64'(bcB),   64'd0);
      checkVal("ar_mc",   64'(mcB),   64'd0);
      checkVal("ar_gidx", 64'(pidxG), 64'h00);
      checkVal("ar_gbc",  64'(bcG),   64'd0);
      brB = 1'b0; brG = 1'b0;
      #2 reset_n = 1'b1;
      tick();
      checkVal("post_pt", 64'(ptB), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
